// File: rtl/dmem_access_ctrl.sv
// Data-memory port sequencer: arbitrates the MEM-stage load/store against an external requester.
// Optional external port and starvation arbitration are enabled by defining DMEM_EXT_PORT_EN.
module dmem_access_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic              pipe_hold,
  output logic              StallM,
  output logic [DATA_W-1:0] ReadDataM,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_done,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // state | meaning
  // IDLE  | no access in flight; arbitration happens here
  // CORE  | MEM-stage command on the memory port, waiting for mem_ready
  // EXT   | external command on the memory port, waiting for mem_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1
`ifdef DMEM_EXT_PORT_EN
    , EXT = 2'd2
`endif
  } state_t;

  state_t              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                done_hold_q, done_hold_d;
  logic                core_req, core_cpl;

  assign core_req = (MemReadM | MemWriteM) & ~done_hold_q;
  assign core_cpl = (state_q == CORE) & mem_ready;

`ifdef DMEM_EXT_PORT_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              ext_done_q, ext_done_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic              ext_gnt_c, ext_cpl, ext_wins;

  assign ext_cpl  = (state_q == EXT) & mem_ready;
  assign ext_wins = ext_req & (starve_q == CNT_W'(STARVE_MAX));
`endif

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    // Remember a finished access while the pipeline is frozen elsewhere so it is not re-issued
    done_hold_d = pipe_hold & (done_hold_q | core_cpl);
`ifdef DMEM_EXT_PORT_EN
    ext_gnt_c   = 1'b0;
    ext_done_d  = ext_cpl;
    ext_rdata_d = (ext_cpl && !mem_we_q) ? mem_rdata : ext_rdata_q;
    starve_d    = starve_q;
    if (!ext_req || ext_cpl) begin
      starve_d = '0;
    end else if (core_cpl && starve_q != CNT_W'(STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
`endif

    case (state_q)
      IDLE: begin
`ifdef DMEM_EXT_PORT_EN
        if (core_req && !ext_wins) begin
`else
        if (core_req) begin
`endif
          state_d     = CORE;
          mem_we_d    = MemWriteM;
          mem_addr_d  = ALUResultM;
          mem_wdata_d = WriteDataM;
`ifdef DMEM_EXT_PORT_EN
        end else if (ext_req) begin
          state_d     = EXT;
          ext_gnt_c   = 1'b1;
          mem_we_d    = ext_we;
          mem_addr_d  = ext_addr;
          mem_wdata_d = ext_wdata;
`endif
        end
      end
      CORE: begin
        if (mem_ready) begin
          state_d = IDLE;
          if (!mem_we_q) rdata_d = mem_rdata;
        end
      end
`ifdef DMEM_EXT_PORT_EN
      EXT: begin
        if (mem_ready) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      done_hold_q <= 1'b0;
`ifdef DMEM_EXT_PORT_EN
      starve_q    <= '0;
      ext_done_q  <= 1'b0;
      ext_rdata_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      done_hold_q <= done_hold_d;
`ifdef DMEM_EXT_PORT_EN
      starve_q    <= starve_d;
      ext_done_q  <= ext_done_d;
      ext_rdata_q <= ext_rdata_d;
`endif
    end
  end

  assign StallM    = core_req & ~core_cpl;
  assign ReadDataM = (core_cpl && !mem_we_q) ? mem_rdata : rdata_q;
  assign mem_en    = (state_q != IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DMEM_EXT_PORT_EN
  assign ext_gnt   = ext_gnt_c & ~rst;
  assign ext_done  = ext_done_q;
  assign ext_rdata = ext_rdata_q;
`else
  logic unused_ext;
  assign unused_ext = ^{ext_req, ext_we, ext_addr, ext_wdata} ^ (STARVE_MAX < 1);
  assign ext_gnt    = 1'b0;
  assign ext_done   = 1'b0;
  assign ext_rdata  = '0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl; external-port scenarios run only when DMEM_EXT_PORT_EN is defined.
module tb_dmem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM, pipe_hold;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_gnt, ext_done;
  logic [31:0] ext_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;

`ifdef DMEM_EXT_PORT_EN
  localparam logic EXT_NOISE = 1'b0;
`else
  localparam logic EXT_NOISE = 1'b1;
`endif

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .pipe_hold(pipe_hold), .StallM(StallM), .ReadDataM(ReadDataM),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_done(ext_done), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; MemReadM = 0; MemWriteM = 0; pipe_hold = 0;
    ALUResultM = 0; WriteDataM = 0; ext_req = 0; ext_we = 0;
    ext_addr = 0; ext_wdata = 0; mem_rdata = 0; mem_ready = 0;

    // reset values
    tick(); #1;
    chk("rst_stall", StallM, 0);     chk("rst_rdata", ReadDataM, 0);
    chk("rst_en", mem_en, 0);        chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);    chk("rst_wdata", mem_wdata, 0);
    chk("rst_gnt", ext_gnt, 0);      chk("rst_done", ext_done, 0);
    chk("rst_erdata", ext_rdata, 0);
    tick(); rst = 1'b0; ext_req = EXT_NOISE; #1;
    chk("idle_en", mem_en, 0);

    // core load 0x40, two wait cycles
    tick(); MemReadM = 1; ALUResultM = 32'h40; #1;
    chk("ld_stall_t0", StallM, 1); chk("ld_en_t0", mem_en, 0); chk("ld_gnt_t0", ext_gnt, 0);
    tick(); #1;
    chk("ld_en_t1", mem_en, 1); chk("ld_addr_t1", mem_addr, 32'h40);
    chk("ld_we_t1", mem_we, 0); chk("ld_stall_t1", StallM, 1);
    tick(); #1;
    chk("ld_stall_t2", StallM, 1); chk("ld_addr_t2", mem_addr, 32'h40);
    tick(); mem_ready = 1; mem_rdata = 32'hDEADBEEF; #1;
    chk("ld_stall_t3", StallM, 0); chk("ld_rdata_t3", ReadDataM, 32'hDEADBEEF);
    chk("ld_addr_t3", mem_addr, 32'h40); chk("ld_gnt_t3", ext_gnt, 0);
    tick(); MemReadM = 0; mem_ready = 0; mem_rdata = 0; #1;
    chk("ld_en_after", mem_en, 0); chk("ld_rdata_held", ReadDataM, 32'hDEADBEEF);
    chk("ld_stall_after", StallM, 0); chk("ld_done_after", ext_done, 0);

    // core store, pipeline held three cycles after completion
    tick(); MemWriteM = 1; ALUResultM = 32'h80; WriteDataM = 32'h12345678; #1;
    chk("st_stall_t0", StallM, 1);
    tick(); mem_ready = 1; pipe_hold = 1; #1;
    chk("st_en", mem_en, 1); chk("st_we", mem_we, 1);
    chk("st_wdata", mem_wdata, 32'h12345678); chk("st_addr", mem_addr, 32'h80);
    chk("st_stall_cpl", StallM, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); mem_ready = 0; #1;
      chk("st_hold_noreissue", mem_en, 0); chk("st_hold_stall", StallM, 0);
    end
    tick(); pipe_hold = 0; #1;
    chk("st_release_en", mem_en, 0); chk("st_release_stall", StallM, 0);
    tick(); MemWriteM = 0; #1;
    chk("st_next_en", mem_en, 0);

    // read and write both set: treated as a store
    tick(); MemReadM = 1; MemWriteM = 1; ALUResultM = 32'h84; WriteDataM = 32'hA0A0A0A0; #1;
    chk("rw_stall_t0", StallM, 1);
    tick(); mem_ready = 1; mem_rdata = 32'h5555AAAA; #1;
    chk("rw_we", mem_we, 1); chk("rw_wdata", mem_wdata, 32'hA0A0A0A0);
    chk("rw_stall_cpl", StallM, 0); chk("rw_rdata_cpl", ReadDataM, 32'hDEADBEEF);
    tick(); MemReadM = 0; MemWriteM = 0; mem_ready = 0; mem_rdata = 0; #1;
    chk("rw_rdata_after", ReadDataM, 32'hDEADBEEF);

    // zero-wait load: one stall cycle
    tick(); MemReadM = 1; ALUResultM = 32'h44; #1;
    chk("zw_stall_t0", StallM, 1);
    tick(); mem_ready = 1; mem_rdata = 32'hA5A50001; #1;
    chk("zw_stall_t1", StallM, 0); chk("zw_rdata_t1", ReadDataM, 32'hA5A50001);
    chk("zw_addr_t1", mem_addr, 32'h44);
    tick(); MemReadM = 0; mem_ready = 0; mem_rdata = 0; #1;
    chk("zw_rdata_held", ReadDataM, 32'hA5A50001);

`ifdef DMEM_EXT_PORT_EN
    // simultaneous core and external: core first
    tick(); MemReadM = 1; ALUResultM = 32'h100; ext_req = 1; ext_we = 0; ext_addr = 32'h200; #1;
    chk("sim_stall_t0", StallM, 1); chk("sim_gnt_t0", ext_gnt, 0);
    tick(); mem_ready = 1; mem_rdata = 32'h11; #1;
    chk("sim_core_addr", mem_addr, 32'h100); chk("sim_stall_cpl", StallM, 0);
    chk("sim_gnt_cpl", ext_gnt, 0);
    tick(); MemReadM = 0; mem_ready = 0; mem_rdata = 0; #1;
    chk("sim_gnt_idle", ext_gnt, 1); chk("sim_en_idle", mem_en, 0);
    tick(); #1;
    chk("sim_gnt_pulse", ext_gnt, 0); chk("sim_ext_en", mem_en, 1);
    chk("sim_ext_addr", mem_addr, 32'h200); chk("sim_ext_we", mem_we, 0);
    chk("sim_ext_stall", StallM, 0);
    tick(); mem_ready = 1; mem_rdata = 32'hCAFE0002; #1;
    chk("sim_done_early", ext_done, 0);
    tick(); mem_ready = 0; mem_rdata = 0; ext_req = 0; #1;
    chk("sim_done", ext_done, 1); chk("sim_erdata", ext_rdata, 32'hCAFE0002);
    chk("sim_gnt_after", ext_gnt, 0);
    tick(); #1;
    chk("sim_done_pulse", ext_done, 0); chk("sim_erdata_held", ext_rdata, 32'hCAFE0002);
    chk("sim_core_rdata", ReadDataM, 32'h11);

    // starvation bound: external wins after four core completions
    ext_we = 1; ext_addr = 32'h300; ext_wdata = 32'h55;
    for (int i = 0; i < 4; i++) begin
      tick(); MemReadM = 1; ALUResultM = 32'h400 + 32'(4 * i); ext_req = 1; mem_ready = 0; #1;
      chk("stv_core_stall", StallM, 1); chk("stv_core_gnt", ext_gnt, 0);
      tick(); mem_ready = 1; mem_rdata = 32'(i); #1;
      chk("stv_core_addr", mem_addr, 32'h400 + 32'(4 * i)); chk("stv_core_cpl", StallM, 0);
    end
    tick(); mem_ready = 0; ALUResultM = 32'h410; #1;
    chk("stv_gnt", ext_gnt, 1); chk("stv_stall_wait", StallM, 1);
    tick(); mem_ready = 1; #1;
    chk("stv_ext_addr", mem_addr, 32'h300); chk("stv_ext_we", mem_we, 1);
    chk("stv_ext_wdata", mem_wdata, 32'h55); chk("stv_stall_ext", StallM, 1);
    tick(); mem_ready = 0; ext_req = 0; #1;
    chk("stv_done", ext_done, 1); chk("stv_erdata_keep", ext_rdata, 32'hCAFE0002);
    chk("stv_stall_idle", StallM, 1); chk("stv_en_idle", mem_en, 0);
    tick(); mem_ready = 1; mem_rdata = 32'h99; #1;
    chk("stv_5th_addr", mem_addr, 32'h410); chk("stv_5th_stall", StallM, 0);
    chk("stv_5th_rdata", ReadDataM, 32'h99);
    tick(); MemReadM = 0; mem_ready = 0; mem_rdata = 0; #1;

    // reset in the middle of an external access
    tick(); ext_req = 1; ext_we = 0; ext_addr = 32'h500; #1;
    chk("rx_gnt", ext_gnt, 1);
    tick(); rst = 1; mem_ready = 1; mem_rdata = 32'hBAD; #1;
    chk("rx_en_before", mem_en, 1);
    tick(); rst = 0; mem_ready = 0; mem_rdata = 0; ext_req = 0; #1;
    chk("rx_en", mem_en, 0);       chk("rx_addr", mem_addr, 0);
    chk("rx_we", mem_we, 0);       chk("rx_wdata", mem_wdata, 0);
    chk("rx_done", ext_done, 0);   chk("rx_erdata", ext_rdata, 0);
    chk("rx_rdata", ReadDataM, 0); chk("rx_stall", StallM, 0);
    chk("rx_gnt_after", ext_gnt, 0);
    tick(); #1;
    chk("rx_done_later", ext_done, 0);
`else
    // external port compiled out: requests are ignored
    tick(); ext_req = 1; #1;
    chk("nx_gnt", ext_gnt, 0);
    tick(); #1;
    chk("nx_en", mem_en, 0); chk("nx_done", ext_done, 0); chk("nx_erdata", ext_rdata, 0);
`endif

    // reset in the middle of a core access
    tick(); MemReadM = 1; ALUResultM = 32'h48; #1;
    chk("rc_stall", StallM, 1);
    tick(); rst = 1; mem_ready = 1; mem_rdata = 32'h77; #1;
    chk("rc_en_before", mem_en, 1);
    tick(); rst = 0; MemReadM = 0; mem_ready = 0; mem_rdata = 0; ext_req = 0; #1;
    chk("rc_en", mem_en, 0); chk("rc_rdata", ReadDataM, 0); chk("rc_addr", mem_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
